// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The fetch_entry_t struct is the unit handed to decode: the word plus its PC.
package fetch_pkg;

    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] PC_STEP       = 32'd4;
    localparam logic [ILEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Force a PC onto a word boundary; the low two bits of a redirect target carry no meaning.
    function automatic logic [ILEN-1:0] align_pc(input logic [ILEN-1:0] raw_pc);
        return raw_pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used twice by the fetch stage: once for returned
// {pc, instr} entries and once for the PCs of requests still in flight.
// The head entry comes straight out of the storage flops, so rdata is a
// registered value and changes only on a clock edge.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type T     = logic [ILEN-1:0],
    parameter int  DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  T                         wdata,
    output T                         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A pop of an empty FIFO is meaningless and ignored; a push into a full
    // FIFO is only accepted when a pop frees the slot in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign rdata = mem[rptr];

    // Pointer and occupancy tracking; flush empties the FIFO and wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the outputs start from a known zero value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word requests to instruction memory,
// buffers returned words with their PCs and hands them to decode under a
// valid/ready handshake. Redirects flush the buffer and arrange for every
// response still in flight to be thrown away when it arrives.
//
// Request credits cover both requests in flight and words already buffered,
// so a returning word always finds room in the entry FIFO.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    output logic             imem_req_o,
    output logic [ILEN-1:0]  imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [ILEN-1:0]  imem_rdata_i,

    input  logic             redirect_i,
    input  logic [ILEN-1:0]  redirect_pc_i,

    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic [ILEN-1:0]  instr_o,
    output logic [ILEN-1:0]  instr_pc_o
);

    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

    logic [ILEN-1:0] pc;
    logic            active;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   discard;
    logic [CW:0]     credits_used;

    logic            issue;
    logic            resp;
    logic            drop;

    logic            entry_push;
    logic            entry_pop;
    logic            entry_full;
    logic            entry_empty;
    logic [CW-1:0]   entry_count;
    fetch_entry_t    entry_in;
    fetch_entry_t    entry_head;

    logic [ILEN-1:0] resp_pc;
    logic            inflight_full;
    logic            inflight_empty;
    logic [CW-1:0]   inflight_count;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign credits_used = {1'b0, outstanding} + {1'b0, entry_count};

    // No request during reset, on a redirect cycle, or when every buffer slot is spoken for.
    assign imem_req_o  = active && !redirect_i && (credits_used < CREDITS);
    assign imem_addr_o = pc;

    assign issue = imem_req_o & imem_gnt_i;

    // A response with nothing outstanding is an environment error and is ignored entirely.
    assign resp = imem_rvalid_i & (outstanding != '0);
    assign drop = resp & (discard != '0);

    // Fetching is held off until the first clock edge after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    // Program counter: redirect target takes priority, otherwise step on each issued request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc <= RESET_PC;
        end else if (redirect_i) begin
            pc <= align_pc(redirect_pc_i);
        end else if (issue) begin
            pc <= pc + PC_STEP;
        end
    end

    // Net change in requests in flight; a grant and a response together cancel out.
    always_comb begin
        outstanding_next = outstanding;
        case ({issue, resp})
            2'b10:   outstanding_next = outstanding + 1'b1;
            2'b01:   outstanding_next = outstanding - 1'b1;
            default: outstanding_next = outstanding;
        endcase
    end

    // Requests in flight, including ones whose data will be discarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding_next;
        end
    end

    // Responses still to be thrown away; a redirect marks everything left in flight as stale.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            discard <= '0;
        end else if (redirect_i) begin
            discard <= outstanding_next;
        end else if (drop) begin
            discard <= discard - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // PCs of requests in flight, consumed in order as responses return
    // ------------------------------------------------------------------
    fetch_fifo #(
        .T     (logic [ILEN-1:0]),
        .DEPTH (FIFO_DEPTH)
    ) u_inflight_q (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .flush (1'b0),
        .push  (issue),
        .pop   (resp),
        .wdata (pc),
        .rdata (resp_pc),
        .full  (inflight_full),
        .empty (inflight_empty),
        .count (inflight_count)
    );

    // ------------------------------------------------------------------
    // Entry buffer towards decode
    // ------------------------------------------------------------------
    assign entry_push = resp & ~drop;
    assign entry_pop  = instr_valid_o & instr_ready_i;

    assign entry_in.pc    = resp_pc;
    assign entry_in.instr = imem_rdata_i;

    fetch_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_entry_q (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .flush (redirect_i),
        .push  (entry_push),
        .pop   (entry_pop),
        .wdata (entry_in),
        .rdata (entry_head),
        .full  (entry_full),
        .empty (entry_empty),
        .count (entry_count)
    );

    assign instr_valid_o = ~entry_empty;
    assign instr_o       = entry_empty ? '0 : entry_head.instr;
    assign instr_pc_o    = entry_empty ? '0 : entry_head.pc;

    // ------------------------------------------------------------------
    // Consistency checks
    // ------------------------------------------------------------------

    // Memory must never return more words than were requested.
    a_rvalid_expected : assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rvalid_i |-> (outstanding != '0));

    // The in-flight PC queue holds exactly one PC per outstanding request.
    a_inflight_tracks : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (inflight_count == outstanding) && (inflight_empty == (outstanding == '0)));

    // Credits keep both queues from ever being pushed while full.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(entry_push && entry_full && !entry_pop) && !(issue && inflight_full && !resp));

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch.
// A behavioural memory returns word memWord(addr) in order, one or more
// cycles after each grant. The reference model is simply the program-order
// stream: fetch addresses and delivered PCs both advance by 4 and restart at
// the redirect target; every delivered word must equal memWord(pc).
// A second instance with a wrap-around reset PC runs alongside.
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC2 = 32'hFFFF_FFF8;
    localparam int          DEPTH     = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;

    logic        imemReq2;
    logic [31:0] imemAddr2;
    logic        imemGnt2 = 1'b1;
    logic        imemRvalid2 = 1'b0;
    logic [31:0] imemRdata2 = 32'h0000_0013;
    logic        redirect2 = 1'b0;
    logic [31:0] redirectPc2 = 32'h0;
    logic        instrValid2;
    logic        instrReady2 = 1'b1;
    logic [31:0] instr2;
    logic [31:0] instrPc2;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] memq[$];
    logic [31:0] grantLog[$];
    logic [31:0] popLog[$];
    logic [31:0] addr2Log[$];
    logic [31:0] fetchPc;
    logic [31:0] expPc;
    logic [31:0] firstPc2;
    bit          prevRedirect;
    bit          pend2;
    bit          seen2;
    int          popCount;
    int          grantCount;
    int          firstValid;

    always #5 clk_i = ~clk_i;

    instruction_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o)
    );

    instruction_fetch #(
        .RESET_PC   (RESET_PC2),
        .FIFO_DEPTH (DEPTH)
    ) dut2 (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .imem_req_o    (imemReq2),
        .imem_addr_o   (imemAddr2),
        .imem_gnt_i    (imemGnt2),
        .imem_rvalid_i (imemRvalid2),
        .imem_rdata_i  (imemRdata2),
        .redirect_i    (redirect2),
        .redirect_pc_i (redirectPc2),
        .instr_valid_o (instrValid2),
        .instr_ready_i (instrReady2),
        .instr_o       (instr2),
        .instr_pc_o    (instrPc2)
    );

    // Contents of instruction memory: a fixed scramble of the address.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Asserts reset mid-cycle, checks the outputs drop at once, resets the model, releases on a falling edge.
    task automatic doReset();
        @(posedge clk_i);
        #1;
        rst_ni        = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imemRvalid2   = 1'b0;
        #1;
        checkOutput("rst_req", 32'(imem_req_o), 32'd0);
        checkOutput("rst_valid", 32'(instr_valid_o), 32'd0);
        checkOutput("rst_instr", instr_o, 32'd0);
        checkOutput("rst_instr_pc", instr_pc_o, 32'd0);
        checkOutput("rst_addr", imem_addr_o, RESET_PC);
        memq.delete();
        grantLog.delete();
        popLog.delete();
        addr2Log.delete();
        fetchPc      = RESET_PC;
        expPc        = RESET_PC;
        prevRedirect = 1'b0;
        pend2        = 1'b0;
        seen2        = 1'b0;
        firstPc2     = 32'h0;
        popCount     = 0;
        grantCount   = 0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // One clock cycle: drive inputs after the rising edge, check and advance the model on the falling edge.
    task automatic applyStimulus(input bit gnt, input bit rvalidEn, input bit ready,
                                 input bit redirect, input logic [31:0] target);
        @(posedge clk_i);
        #1;
        imem_gnt_i    = gnt;
        imem_rvalid_i = rvalidEn && (memq.size() > 0);
        imem_rdata_i  = (memq.size() > 0) ? memWord(memq[0]) : 32'h0;
        instr_ready_i = ready;
        redirect_i    = redirect;
        redirect_pc_i = target;
        imemRvalid2   = pend2;
        @(negedge clk_i);

        if (prevRedirect) checkOutput("valid_after_redirect", 32'(instr_valid_o), 32'd0);
        if (redirect) checkOutput("req_during_redirect", 32'(imem_req_o), 32'd0);
        if (imem_req_o) begin
            checkOutput("fetch_addr", imem_addr_o, fetchPc);
            checkOutput("credit_limit", 32'(memq.size() < DEPTH), 32'd1);
        end
        if (instr_valid_o) begin
            checkOutput("instr_pc", instr_pc_o, expPc);
            checkOutput("instr_word", instr_o, memWord(expPc));
        end

        if (imem_rvalid_i) void'(memq.pop_front());
        if (redirect) begin
            fetchPc = target & 32'hFFFF_FFFC;
            expPc   = target & 32'hFFFF_FFFC;
        end else begin
            if (imem_req_o && gnt) begin
                memq.push_back(imem_addr_o);
                grantLog.push_back(imem_addr_o);
                fetchPc = fetchPc + 32'd4;
                grantCount++;
            end
            if (instr_valid_o && ready) begin
                popLog.push_back(instr_pc_o);
                expPc = expPc + 32'd4;
                popCount++;
            end
        end
        prevRedirect = redirect;

        if (imemReq2) addr2Log.push_back(imemAddr2);
        pend2 = imemReq2;
        if (instrValid2 && !seen2) begin
            seen2    = 1'b1;
            firstPc2 = instrPc2;
        end
    endtask

    initial begin
        bit rGnt;
        bit rRvalid;
        bit rReady;
        bit rRedirect;
        logic [31:0] rTarget;

        $display("[TB] start");
        doReset();

        // Free-running fetch: sequential addresses, two-cycle grant-to-valid latency.
        firstValid = -1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            if (instr_valid_o && firstValid < 0) firstValid = i;
        end
        checkOutput("t1_first_valid_cycle", 32'(firstValid), 32'd2);
        checkOutput("t1_grant_count", 32'(grantLog.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < grantLog.size(); i++)
            checkOutput("t1_addr_seq", grantLog[i], RESET_PC + 32'(4 * i));
        checkOutput("t1_progress", 32'(popCount >= 4), 32'd1);

        // Wrap-around instance ran in parallel from the same reset.
        checkOutput("t5_addr_count", 32'(addr2Log.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < addr2Log.size(); i++)
            checkOutput("t5_addr_seq", addr2Log[i], RESET_PC2 + 32'(4 * i));
        checkOutput("t5_first_pc", firstPc2, RESET_PC2);

        // Decode stalled: only DEPTH requests go out, head word held, then drains without loss.
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("t2_grants_stalled", 32'(grantCount), 32'(DEPTH));
        checkOutput("t2_valid_held", 32'(instr_valid_o), 32'd1);
        checkOutput("t2_held_pc", instr_pc_o, RESET_PC);
        checkOutput("t2_held_word", instr_o, memWord(RESET_PC));
        popLog.delete();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t2_resume_first", (popLog.size() > 0) ? popLog[0] : 32'hDEAD_BEEF, RESET_PC);
        checkOutput("t2_resume_progress", 32'(popLog.size() >= 4), 32'd1);

        // Redirect with two requests in flight: stale words never reach decode.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t3_outstanding", 32'(memq.size()), 32'd2);
        popLog.delete();
        grantLog.delete();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t3_first_addr", (grantLog.size() > 0) ? grantLog[0] : 32'hDEAD_BEEF, 32'h0000_0100);
        checkOutput("t3_first_pc", (popLog.size() > 0) ? popLog[0] : 32'hDEAD_BEEF, 32'h0000_0100);

        // Redirect coinciding with a grant and a returning response.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        popLog.delete();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2002);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t4_first_pc", (popLog.size() > 0) ? popLog[0] : 32'hDEAD_BEEF, 32'h0000_2000);
        checkOutput("t4_progress", 32'(popLog.size() >= 4), 32'd1);

        // Reset in the middle of a burst.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t6_pre_valid", 32'(instr_valid_o), 32'd1);
        checkOutput("t6_pre_outstanding", 32'(memq.size()), 32'd1);
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t6_req_after_reset", 32'(imem_req_o), 32'd1);
        checkOutput("t6_addr_after_reset", imem_addr_o, RESET_PC);

        // Randomised traffic: grants, response timing, decode stalls and redirects.
        doReset();
        for (int i = 0; i < 800; i++) begin
            rGnt      = ($urandom_range(0, 3) != 0);
            rRvalid   = ($urandom_range(0, 2) != 0);
            rReady    = ($urandom_range(0, 3) != 0);
            rRedirect = ($urandom_range(0, 15) == 0);
            rTarget   = $urandom;
            applyStimulus(rGnt, rRvalid, rReady, rRedirect, rTarget);
        end
        checkOutput("rand_progress", 32'(popCount >= 50), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
